// File: rtl/vpi_file_io_arbiter.sv
// Round-robin arbiter/sequencer sharing one binary-file I/O channel among NUM_REQ requesters.
// One transaction in flight; reads after end-of-file are answered locally without the channel.
module vpi_file_io_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 40,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                          aclk,
    input  logic                          arstn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic signed [31:0]            rsp_count,
    output logic                          rsp_eof,
    output logic                          rsp_error,
    output logic                          io_valid,
    output logic                          io_write,
    output logic [DATA_WIDTH-1:0]         io_data,
    input  logic                          io_ready,
    input  logic                          io_done,
    input  logic signed [31:0]            io_count,
    input  logic [DATA_WIDTH-1:0]         io_rdata
);

    localparam int unsigned IdxW    = $clog2(NUM_REQ);
    localparam logic [15:0] TmoLast = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e            state_q;
    logic [IdxW-1:0]   ptr_q;
    logic [IdxW-1:0]   gnt_q;
    logic              wr_q;
    logic              eof_q;
    logic [15:0]       tmo_q;

    logic                  gnt_found;
    logic [IdxW-1:0]       gnt_idx;
    logic                  gnt_write;
    logic [DATA_WIDTH-1:0] gnt_data;
    logic [IdxW-1:0]       ptr_nxt;
    logic [NUM_REQ-1:0]    gnt_oh;
    logic                  io_complete;
    logic                  done_eof;
    logic [DATA_WIDTH-1:0] done_data;

    // Rotating priority: first pass only looks at or above the pointer, second pass wraps.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        gnt_write = 1'b0;
        gnt_data  = '0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!gnt_found && req_valid[i] && (pass == 1 || i >= 32'(ptr_q))) begin
                    gnt_found = 1'b1;
                    gnt_idx   = IdxW'(i);
                    gnt_write = req_write[i];
                    gnt_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
        ptr_nxt = (gnt_idx == IdxW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end

    // Accept pulse is issued in the same cycle the grant is decided; suppressed while in reset.
    always_comb begin
        req_ready = '0;
        if (arstn && state_q == StIdle && gnt_found) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    // Completion decode: channel result as it will be routed back to the granted requester.
    always_comb begin
        gnt_oh         = '0;
        gnt_oh[gnt_q]  = 1'b1;
        io_complete    = io_done && ((state_q == StIssue && io_ready) || state_q == StWait);
        done_eof       = !wr_q && (io_count < 0);
        done_data      = (wr_q || done_eof) ? '0 : io_rdata;
    end

    // Sequencer FSM with registered channel and response outputs.
    always_ff @(posedge aclk) begin
        if (!arstn) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            gnt_q     <= '0;
            wr_q      <= 1'b0;
            eof_q     <= 1'b0;
            tmo_q     <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_count <= '0;
            rsp_eof   <= 1'b0;
            rsp_error <= 1'b0;
            io_valid  <= 1'b0;
            io_write  <= 1'b0;
            io_data   <= '0;
        end else begin
            // Response fields are single-cycle; they fall back to zero unless set below.
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_count <= '0;
            rsp_eof   <= 1'b0;
            rsp_error <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (gnt_found) begin
                        gnt_q <= gnt_idx;
                        wr_q  <= gnt_write;
                        ptr_q <= ptr_nxt;
                        if (!gnt_write && eof_q) begin
                            // File already exhausted: answer without touching the channel.
                            state_q   <= StResp;
                            rsp_valid <= req_ready;
                            rsp_count <= -32'sd1;
                            rsp_eof   <= 1'b1;
                        end else begin
                            state_q  <= StIssue;
                            io_valid <= 1'b1;
                            io_write <= gnt_write;
                            io_data  <= gnt_data;
                        end
                    end
                end
                StIssue: begin
                    if (io_ready) begin
                        io_valid <= 1'b0;
                        io_write <= 1'b0;
                        io_data  <= '0;
                        tmo_q    <= '0;
                        state_q  <= io_done ? StResp : StWait;
                    end
                end
                StWait: begin
                    if (io_done) begin
                        state_q <= StResp;
                    end else if (tmo_q == TmoLast) begin
                        state_q   <= StResp;
                        rsp_valid <= gnt_oh;
                        rsp_error <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
            if (io_complete) begin
                rsp_valid <= gnt_oh;
                rsp_data  <= done_data;
                rsp_count <= io_count;
                rsp_eof   <= done_eof;
                if (done_eof) begin
                    eof_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/vpi_file_io_arbiter.md
Name: vpi_file_io_arbiter

Overview:
Round-robin arbiter and sequencer that shares one VPI binary-file I/O channel among NUM_REQ simulation requesters. Each requester posts a read or write transaction. The block grants one requester at a time, drives the single io_* channel to the wrapper that performs $read_binary_file/$write_binary_file, waits for completion or timeout, and routes the result back. It sits between bench-side stream models and the VPI call wrapper. It tracks end-of-file (negative read count) so exhausted reads are answered without touching the file.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_WIDTH, 40, transaction data width in bits
TIMEOUT, 255, max cycles waiting for io_done before error (1..65535)

Ports:
aclk  in  1  clock, all logic on rising edge
arstn  in  1  synchronous active-low reset
req_valid  in  NUM_REQ  per-requester transaction request, held until req_ready
req_write  in  NUM_REQ  1=write, 0=read, per requester
req_data  in  NUM_REQ*DATA_WIDTH  write data; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse
rsp_valid  out  NUM_REQ  one-hot, one-cycle response strobe to the granted requester
rsp_data  out  DATA_WIDTH  read data; 0 for writes, EOF and error
rsp_count  out  32  signed count returned by the channel
rsp_eof  out  1  qualifies rsp_valid: read hit EOF
rsp_error  out  1  qualifies rsp_valid: timeout
io_valid  out  1  channel command valid
io_write  out  1  channel command type
io_data  out  DATA_WIDTH  channel write data
io_ready  in  1  channel accepts command when high with io_valid
io_done  in  1  one-cycle completion strobe
io_count  in  32  signed count, sampled with io_done
io_rdata  in  DATA_WIDTH  read data, sampled with io_done

Behaviour:
- Reset (arstn=0 at edge): state IDLE; all outputs 0; rr pointer 0; eof flag 0; timeout counter 0. Reset mid-transaction abandons it: no rsp_valid is issued, and late io_done is ignored in IDLE.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid is high, the grant is the first index at or above the pointer, wrapping modulo NUM_REQ.
  - Pulse req_ready[g] for that cycle; latch g, req_write[g] and the data slice; set pointer = (g+1) mod NUM_REQ.
  - Latched read with eof flag set: go straight to RESP with count=-1, eof=1.
  - Otherwise go to ISSUE.
- ISSUE: io_valid=1 with latched io_write/io_data, stable until io_ready.
  - io_valid&io_ready: go to WAIT; clear counter.
  - io_done arriving in the same cycle as io_ready is accepted and goes directly to RESP.
- WAIT: counter increments each cycle.
  - io_done: capture io_count and io_rdata (rdata forced to 0 on writes), then go to RESP.
  - io_count<0 on a read: set the sticky eof flag; rsp_eof=1.
  - Counter reaching TIMEOUT without io_done: go to RESP with rsp_error=1, count=0.
- RESP: rsp_valid[g]=1 for exactly one cycle with rsp_data/count/eof/error valid, then IDLE.
  - Response fields return to 0 when rsp_valid is low.
- Throughput: at most one transaction in flight.
  - Minimum latency from req_ready to rsp_valid is 3 cycles when io_ready=1 and io_done is in the first WAIT cycle.
  - EOF short-circuit latency is 1 cycle.
- Writes are never blocked by the eof flag. The eof flag clears only on reset.
- A requester dropping req_valid before grant is legal. A requester changing req_write/req_data before req_ready is undefined.
- io_done outside WAIT/ISSUE is ignored.

Test Plan:
- Single read: req_valid[0]=1, io_ready=1, io_done next cycle with count=5, rdata=40'h0102030405 -> req_ready=0001, then rsp_valid=0001 with rsp_data=40'h0102030405, count=5, eof=0, three cycles after req_ready.
- Round-robin: all four req_valid held high for 8 transactions -> grant order 0,1,2,3,0,1,2,3 with no requester starved.
- EOF: read returns io_count=-1 -> rsp_eof=1. The next read from requester 2 gets rsp_valid one cycle after grant with count=-1, io_valid never asserted. A subsequent write still issues on io_*.
- Backpressure/timeout: io_ready held 0 for 10 cycles then 1, io_done never sent, TIMEOUT=20 -> io_valid and io_data stable throughout ISSUE; rsp_error=1, count=0, 20 cycles after entering WAIT.
- Reset mid-op: arstn low during WAIT, then io_done after reset -> no rsp_valid, pointer 0, eof cleared, and the next read issues normally.
- Write path: req_write[3]=1, data=40'hAA, io_done count=5 -> io_write=1, io_data=40'hAA; rsp_valid=1000 with rsp_data=0, count=5.
